// File: rtl/braille_cell_driver.sv
// braille_cell_driver: buffers classified letters in a small FIFO and shows each one
// as a 6-dot Braille cell for HOLD_CYCLES, followed by a blank gap of GAP_CYCLES.
// Optional feature macro BRAILLE_SCAN_EN: scan the lit dots one slot at a time
// (SCAN_CYCLES per slot) for boards that can drive only one dot at once.
module braille_cell_driver #(
    parameter int ALPHA_BW    = 5,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 100000000,
    parameter int GAP_CYCLES  = 20000000,
    parameter int SCAN_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [ALPHA_BW-1:0] in_alpha,
    output logic [5:0]          out_dots,
    output logic                out_char_vld,
    output logic [ALPHA_BW-1:0] out_alpha,
    output logic                out_invalid,
    output logic                out_busy,
    output logic                out_overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int MAX_C  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W  = $clog2(MAX_C + 1);
    localparam int SCAN_W = $clog2(SCAN_CYCLES + 1);

    // Reject parameter values the logic below cannot honour.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
        $error("FIFO_DEPTH must be a power of 2 and >= 2");
    if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || SCAN_CYCLES < 1)
        $error("HOLD_CYCLES, GAP_CYCLES and SCAN_CYCLES must be >= 1");

    typedef enum logic [1:0] {IDLE, LOAD, SHOW, GAP} state_t;

    // Dots for the first decade a..j; the other decades are derived from it.
    function automatic logic [5:0] base_cell(input int i);
        case (i)
            0:       base_cell = 6'b000001;
            1:       base_cell = 6'b000011;
            2:       base_cell = 6'b001001;
            3:       base_cell = 6'b011001;
            4:       base_cell = 6'b010001;
            5:       base_cell = 6'b001011;
            6:       base_cell = 6'b011011;
            7:       base_cell = 6'b010011;
            8:       base_cell = 6'b001010;
            default: base_cell = 6'b011010;
        endcase
    endfunction

    // Full letter table; 'w' is the odd one out because it was added to the alphabet late.
    function automatic logic [5:0] cell_pattern(input logic [ALPHA_BW-1:0] idx);
        int i;
        i = int'(idx);
        if (i < 10)       cell_pattern = base_cell(i);
        else if (i < 20)  cell_pattern = base_cell(i - 10) | 6'b000100;
        else if (i == 22) cell_pattern = 6'b111010;
        else if (i < 22)  cell_pattern = base_cell(i - 20) | 6'b100100;
        else if (i < 26)  cell_pattern = base_cell(i - 21) | 6'b100100;
        else              cell_pattern = 6'b111111;
    endfunction

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt;
    logic [ALPHA_BW-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        count;
    logic                  full, empty, push, pop;
    logic [ALPHA_BW-1:0]   alpha_q;
    logic [5:0]            pattern_q;
    logic                  invalid_q;
    logic                  overflow_q;
    logic                  show_entry;

    assign full       = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign pop        = (state == LOAD);
    // A full FIFO can still take the strobe if LOAD frees a slot in the same cycle.
    assign push       = in_valid && (!full || pop);
    assign show_entry = (state_next == SHOW) && (state != SHOW);

    // FIFO storage; no reset needed, occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_alpha;
    end

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (in_valid && full && !pop) overflow_q <= 1'b1;
        end
    end

    // State register plus one shared cycle counter, cleared on every state entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state_next != state || state == IDLE) cnt <= '0;
            else                                      cnt <= cnt + 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (!empty) state_next = LOAD;
            LOAD: state_next = SHOW;
            SHOW: if (cnt == CNT_W'(HOLD_CYCLES - 1)) state_next = GAP;
            GAP:  if (cnt == CNT_W'(GAP_CYCLES - 1))  state_next = empty ? IDLE : LOAD;
            default: state_next = IDLE;
        endcase
    end

    // Latch the popped letter and its cell while in LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            alpha_q   <= '0;
            pattern_q <= '0;
            invalid_q <= 1'b0;
        end else if (state == LOAD) begin
            alpha_q   <= mem[rd_ptr];
            pattern_q <= cell_pattern(mem[rd_ptr]);
            invalid_q <= (int'(mem[rd_ptr]) >= 26);
        end
    end

`ifdef BRAILLE_SCAN_EN
    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0]        slot;

    // Step through dot slots 0..5; unlit slots still take their full time.
    always_ff @(posedge clk) begin
        if (reset || show_entry) begin
            scan_cnt <= '0;
            slot     <= '0;
        end else if (state == SHOW) begin
            if (scan_cnt == SCAN_W'(SCAN_CYCLES - 1)) begin
                scan_cnt <= '0;
                slot     <= (slot == 3'd5) ? 3'd0 : slot + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    assign out_dots = (state == SHOW) ? (pattern_q & (6'b000001 << slot)) : 6'b000000;
`else
    logic unused_entry;
    assign unused_entry = show_entry;
    assign out_dots     = (state == SHOW) ? pattern_q : 6'b000000;
`endif

    assign out_char_vld = (state == SHOW);
    assign out_alpha    = alpha_q;
    assign out_invalid  = (state == SHOW) && invalid_q;
    assign out_busy     = (state != IDLE) || !empty;
    assign out_overflow = overflow_q;

endmodule

// File: tb/tb_braille_cell_driver.sv
// Directed bench for braille_cell_driver: table of single letters plus hand-written
// burst, overflow, reset-abort and (with BRAILLE_SCAN_EN) dot-scan sequences.
module tb_braille_cell_driver;

`ifdef BRAILLE_SCAN_EN
    localparam int HOLD = 12;
`else
    localparam int HOLD = 4;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [4:0] in_alpha;
    logic [5:0] out_dots;
    logic       out_char_vld;
    logic [4:0] out_alpha;
    logic       out_invalid;
    logic       out_busy;
    logic       out_overflow;

    int pass_cnt  = 0;
    int total_cnt = 0;

    braille_cell_driver #(
        .ALPHA_BW(5), .FIFO_DEPTH(4), .HOLD_CYCLES(HOLD), .GAP_CYCLES(2), .SCAN_CYCLES(2)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_alpha(in_alpha),
        .out_dots(out_dots), .out_char_vld(out_char_vld), .out_alpha(out_alpha),
        .out_invalid(out_invalid), .out_busy(out_busy), .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] alpha;
        logic [5:0] dots;
        logic       inv;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic all_zero(input string nm);
        chk(nm, {out_dots, out_char_vld, out_alpha, out_invalid, out_busy, out_overflow}, 32'd0);
    endtask

    task automatic wait_vld(input logic val);
        int n = 0;
        while (out_char_vld !== val && n < 60) begin step(); n++; end
        chk("wait_vld", {31'd0, out_char_vld}, {31'd0, val});
    endtask

    task automatic wait_idle();
        int n = 0;
        while (out_busy !== 1'b0 && n < 100) begin step(); n++; end
        chk("wait_idle", {31'd0, out_busy}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // One letter into an idle block: shown N+3..N+6, blank N+7..N+8, idle from N+9.
    task automatic run_letter(input vec_t v);
        in_valid = 1'b1;
        in_alpha = v.alpha;
        step();
        in_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            chk("show_dots",  {26'd0, out_dots}, {26'd0, v.dots});
            chk("show_vld",   {31'd0, out_char_vld}, 32'd1);
            chk("show_inv",   {31'd0, out_invalid}, {31'd0, v.inv});
            chk("show_alpha", {27'd0, out_alpha}, {27'd0, v.alpha});
            step();
        end
        for (int i = 0; i < 2; i++) begin
            chk("gap_dots", {26'd0, out_dots}, 32'd0);
            chk("gap_vld",  {31'd0, out_char_vld}, 32'd0);
            chk("gap_busy", {31'd0, out_busy}, 32'd1);
            step();
        end
        chk("idle_busy",  {31'd0, out_busy}, 32'd0);
        chk("hold_alpha", {27'd0, out_alpha}, {27'd0, v.alpha});
    endtask

    initial begin
        logic [5:0] bp [3];
        logic [5:0] scan_exp [6];

        vecs[0] = '{5'd0,  6'b000001, 1'b0};  // a
        vecs[1] = '{5'd9,  6'b011010, 1'b0};  // j
        vecs[2] = '{5'd22, 6'b111010, 1'b0};  // w
        vecs[3] = '{5'd25, 6'b110101, 1'b0};  // z
        vecs[4] = '{5'd30, 6'b111111, 1'b1};  // invalid
        vecs[5] = '{5'd10, 6'b000101, 1'b0};  // k
        vecs[6] = '{5'd19, 6'b011110, 1'b0};  // t
        vecs[7] = '{5'd20, 6'b100101, 1'b0};  // u
        vecs[8] = '{5'd23, 6'b101101, 1'b0};  // x
        vecs[9] = '{5'd1,  6'b000011, 1'b0};  // b

        reset    = 1'b1;
        in_valid = 1'b0;
        in_alpha = 5'd0;
        step();
        step();
        reset = 1'b0;
        all_zero("reset_state");
        for (int i = 0; i < 20; i++) begin
            step();
            all_zero("idle_quiet");
        end

`ifdef BRAILLE_SCAN_EN
        // 'd' = dots 1,4,5 scanned one slot per 2 cycles.
        scan_exp = '{6'b000001, 6'b000000, 6'b000000, 6'b001000, 6'b010000, 6'b000000};
        in_valid = 1'b1;
        in_alpha = 5'd3;
        step();
        in_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 12; i++) begin
            chk("scan_dots", {26'd0, out_dots}, {26'd0, scan_exp[i/2]});
            chk("scan_vld",  {31'd0, out_char_vld}, 32'd1);
            step();
        end
        chk("scan_gap", {26'd0, out_dots, out_char_vld}, 32'd0);
        wait_idle();
`else
        for (int v = 0; v < 10; v++) run_letter(vecs[v]);

        // Burst j,w,z on consecutive cycles: each cell 4 cycles, 2-cycle gap, 1 LOAD cycle.
        bp = '{6'b011010, 6'b111010, 6'b110101};
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_alpha = vecs[i+1].alpha;
            step();
        end
        in_valid = 1'b0;
        for (int off = 3; off <= 24; off++) begin
            logic [5:0] ed;
            ed = 6'b000000;
            for (int k = 0; k < 3; k++)
                if (off >= 3 + 7*k && off <= 6 + 7*k) ed = bp[k];
            chk("burst_dots", {26'd0, out_dots}, {26'd0, ed});
            chk("burst_busy", {31'd0, out_busy}, (off <= 22) ? 32'd1 : 32'd0);
            step();
        end

        // Six strobes from idle: five accepted, sixth dropped.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_alpha = 5'(i);
            step();
        end
        in_valid = 1'b0;
        chk("ovf_set", {31'd0, out_overflow}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            wait_vld(1'b1);
            chk("ovf_order", {27'd0, out_alpha}, k);
            wait_vld(1'b0);
        end
        wait_idle();
        chk("ovf_last",   {27'd0, out_alpha}, 32'd4);
        chk("ovf_sticky", {31'd0, out_overflow}, 32'd1);
        do_reset();
        chk("ovf_clear",  {31'd0, out_overflow}, 32'd0);

        // Reset in the middle of SHOW with a second letter still queued.
        in_valid = 1'b1;
        in_alpha = 5'd2;
        step();
        in_alpha = 5'd3;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("mid_show", {31'd0, out_char_vld}, 32'd1);
        do_reset();
        all_zero("abort_zero");
        for (int i = 0; i < 10; i++) begin
            step();
            all_zero("abort_empty");
        end
        run_letter(vecs[9]);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
